// File: rtl/vstream_wr_pkg.sv
// Shared types and helpers for the vstream_wr_mc multi-channel stream-to-memory writer.
package vstream_wr_pkg;

  typedef enum logic [1:0] {
    ST_ARB,
    ST_ISSUE,
    ST_RESP
  } state_e;

  // Byte stride between consecutive words of one channel.
  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/vstream_wr_mc_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter
  import vstream_wr_pkg::*;
#(
  parameter  int NUM_CH = 2,
  localparam int IW     = ch_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic              gnt_valid
);

  logic [NUM_CH-1:0] req_rot;
  logic [NUM_CH-1:0] gnt_rot;

  // Rotate so the pointer position sits at bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    req_rot   = NUM_CH'({req, req} >> ptr);
    gnt_rot   = '0;
    gnt_valid = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (req_rot[k] && !gnt_valid) begin
        gnt_rot[k] = 1'b1;
        gnt_valid  = 1'b1;
      end
    end
    gnt = NUM_CH'({gnt_rot, gnt_rot} >> (NUM_CH - int'(ptr)));
  end

endmodule

// File: rtl/vstream_wr_mc.sv
// Multi-channel stream-to-memory writer, one AXI-lite write outstanding, round-robin per beat.
// Optional VSTREAM_WR_ERR_ABORT_EN: an error response terminates the channel immediately.
module vstream_wr_mc
  import vstream_wr_pkg::*;
#(
  parameter  int NUM_CH     = 2,
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 32,
  parameter  int CNT_WIDTH  = 16,
  localparam int CW         = ch_idx_w(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_valid,
  input  logic [CW-1:0]                cfg_ch,
  input  logic [ADDR_WIDTH-1:0]        cfg_base,
  input  logic [CNT_WIDTH-1:0]         cfg_len,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_CH-1:0]            s_valid,
  input  logic [NUM_CH-1:0]            s_last,
  output logic [NUM_CH-1:0]            s_ready,
  output logic [ADDR_WIDTH-1:0]        m_waddr,
  output logic                         m_wavalid,
  input  logic                         m_waready,
  output logic [DATA_WIDTH-1:0]        m_wdata,
  output logic                         m_wvalid,
  input  logic                         m_wready,
  input  logic                         m_wresp,
  input  logic                         m_bvalid,
  output logic                         m_bready,
  output logic [NUM_CH-1:0]            busy,
  output logic [NUM_CH-1:0]            done,
  output logic [NUM_CH-1:0]            err
);

  localparam int BYTES_PER_WORD = bytes_per_word(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [CW-1:0]         ptr_q, ptr_d, cur_q, cur_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  last_q, last_d, awv_q, awv_d, wv_q, wv_d;

  logic [ADDR_WIDTH-1:0] base_q [NUM_CH];
  logic [ADDR_WIDTH-1:0] base_d [NUM_CH];
  logic [CNT_WIDTH-1:0]  len_q  [NUM_CH];
  logic [CNT_WIDTH-1:0]  len_d  [NUM_CH];
  logic [CNT_WIDTH-1:0]  cnt_q  [NUM_CH];
  logic [CNT_WIDTH-1:0]  cnt_d  [NUM_CH];
  logic [NUM_CH-1:0]     busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [NUM_CH-1:0]     elig, gnt;
  logic                  gnt_valid;
  logic [CW-1:0]         gidx;
  logic [CNT_WIDTH-1:0]  cnt_inc;
  logic                  fin;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      elig[c] = busy_q[c] && s_valid[c] && (cnt_q[c] < len_q[c]);
    end
  end

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req       (elig),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    gidx = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt[c]) gidx = CW'(c);
    end
  end

  // NOTE: every signal written here gets its default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    awv_d   = awv_q;
    wv_d    = wv_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    s_ready  = '0;
    m_bready = 1'b0;
    cnt_inc  = cnt_q[cur_q] + CNT_WIDTH'(1);
    fin      = 1'b0;

    case (state_q)
      ST_ARB: begin
        if (gnt_valid) begin
          s_ready = gnt;
          cur_d   = gidx;
          waddr_d = base_q[gidx] + ADDR_WIDTH'(cnt_q[gidx]) * ADDR_WIDTH'(BYTES_PER_WORD);
          wdata_d = s_data[gidx*DATA_WIDTH +: DATA_WIDTH];
          last_d  = s_last[gidx];
          ptr_d   = (gidx == CW'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
          awv_d   = 1'b1;
          wv_d    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_waready) awv_d = 1'b0;
        if (m_wready)  wv_d  = 1'b0;
        if ((!awv_q || m_waready) && (!wv_q || m_wready)) state_d = ST_RESP;
      end
      ST_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          cnt_d[cur_q] = cnt_inc;
          err_d[cur_q] = err_q[cur_q] | m_wresp;
          fin          = last_q || (cnt_inc == len_q[cur_q]);
`ifdef VSTREAM_WR_ERR_ABORT_EN
          fin          = fin || m_wresp;
`else
          fin          = fin;
`endif
          if (fin) begin
            busy_d[cur_q] = 1'b0;
            done_d[cur_q] = 1'b1;
          end
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase

    // Arming only touches idle channels, so it never collides with the beat in flight.
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_valid && !busy_q[c] && (cfg_ch == CW'(c))) begin
        base_d[c] = cfg_base;
        len_d[c]  = cfg_len;
        cnt_d[c]  = '0;
        err_d[c]  = 1'b0;
        done_d[c] = (cfg_len == '0);
        busy_d[c] = (cfg_len != '0);
      end
    end
  end

  // NOTE: the per-channel arrays are a handful of registers, not a RAM, so they take the async reset like everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARB;
      ptr_q   <= '0;
      cur_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      awv_q   <= 1'b0;
      wv_q    <= 1'b0;
      busy_q  <= '0;
      done_q  <= '0;
      err_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        base_q[c] <= '0;
        len_q[c]  <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      awv_q   <= awv_d;
      wv_q    <= wv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_waddr   = waddr_q;
  assign m_wdata   = wdata_q;
  assign m_wavalid = awv_q;
  assign m_wvalid  = wv_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
